sprite_blitter: RTL and testbench
=================================

Name: sprite_blitter

Overview:
- Drawing engine that reads a W x H sprite out of a synchronous object memory (object_mem-style ROM, 1-cycle read latency).
- Emits one VGA-adapter pixel write per opaque, on-screen texel at a latched screen origin.
- Acts as the reader/initiator on the object-memory port, and as the writer toward the VGA adapter (x, y, colour, plot).
- Sits between the game-logic FSM (start/done handshake) and the VGA adapter.

Parameters:
- W, 32, sprite width in texels; power of two.
- H, 32, sprite height in texels.
- AW, 10, object-memory address width; W*H <= 2^AW.
- XW, 8, screen x width.
- YW, 7, screen y width.
- SCREEN_W, 160, visible columns.
- SCREEN_H, 120, visible rows.
- TRANSP, 8'hEE, colour code treated as transparent (never plotted).

Ports:
- Clock  in  1  system clock, all logic on posedge.
- Resetn  in  1  synchronous, active-low reset.
- start  in  1  request a blit; sampled only in IDLE.
- x0  in  XW  sprite origin x; latched with start.
- y0  in  YW  sprite origin y; latched with start.
- mem_addr  out  AW  object-memory read address.
- mem_data  in  8  object-memory read data; valid the cycle after mem_addr is presented.
- vga_x  out  XW  pixel x to VGA adapter.
- vga_y  out  YW  pixel y to VGA adapter.
- vga_colour  out  8  pixel colour.
- plot  out  1  VGA write strobe; one pixel per high cycle.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: already decided — reset Resetn, synchronous, active-low; clock Clock. On reset:
  - state IDLE, counters and pipeline cleared.
  - mem_addr, vga_x, vga_y, vga_colour, plot, busy and done are all 0.
  - Reset mid-blit aborts immediately: no further plot and no done pulse.
- States IDLE, FETCH, DRAIN.
- IDLE:
  - start=1 at an edge latches x0/y0, clears col/row, and moves to FETCH.
  - start outside IDLE is ignored.
  - The cycle carrying done is in IDLE, so start in that cycle is accepted (back-to-back blits).
- FETCH:
  - mem_addr = row*W + col, i.e. {row, col[log2 W-1:0]}.
  - col increments each cycle; at col=W-1, col wraps to 0 and row increments.
  - After presenting (col=W-1, row=H-1), go to DRAIN.
- DRAIN:
  - 2 cycles to flush the pipeline, then IDLE with done=1 for exactly one cycle.
- Pipeline:
  - Stage 1 delays col/row/valid by one cycle to align with mem_data.
  - Stage 2 registers the outputs.
  - Texel n (addressed in cycle F+n) appears on vga_x/vga_y/vga_colour/plot in cycle F+n+2.
- Plot qualification:
  - plot = valid & (mem_data != TRANSP) & (x0+col < SCREEN_W) & (y0+row < SCREEN_H).
  - Sums are computed in XW+1 / YW+1 bits, so there is no wrap-around; off-screen texels are clipped, never wrapped.
  - vga_x = x0+col and vga_y = y0+row (truncated to XW/YW), valid only when plot=1.
  - vga_x/vga_y/vga_colour may hold any value when plot=0.
- Timing (start sampled at edge E0; cycle 1 is the first FETCH cycle):
  - Texel n is addressed in cycle n+1 and its plot appears in cycle n+3.
  - Last plot opportunity is cycle W*H+2.
  - done=1 and busy=0 in cycle W*H+3, independent of transparency or clipping.
- busy is 1 in all FETCH and DRAIN cycles.
- mem_addr is held at 0 outside FETCH.

Test Plan:
- Reset: hold Resetn=0 two cycles with start=1 -> plot=0, busy=0, done=0, mem_addr=0; no blit starts.
- Full blit: registered ROM model mem_data=addr[7:0] (0xEE forced to 0x01), x0=10, y0=5, start one cycle.
  - First plot in cycle 3 at (10,5) with colour 0x00.
  - Exactly 1024 plots; texel 33 plotted at (11,6) with colour 0x21.
  - done pulses in cycle 1027; busy is high in cycles 1..1026.
- Transparency: ROM returns 0xEE for even addresses, 0x3C for odd, x0=0, y0=0.
  - Exactly 512 plots, all colour 0x3C, all at odd x.
  - done still in cycle 1027.
- Clipping: x0=150, y0=100.
  - Plots only for col<10 and row<20, i.e. 200 plots.
  - Max vga_x=159, max vga_y=119; no wrapped coordinates.
- Handshake: pulse start again in cycle 500 with a different origin -> ignored, no change to output coordinates. Then assert start during the done cycle (1027) -> second blit accepted, first address in cycle 1028.
- Reset mid-operation: Resetn=0 at cycle 300 -> from the next cycle plot=0, busy=0; done never pulses. A new start after reset produces a fresh 1024-cycle blit from address 0.

Source files
------------

// File: rtl/sprite_blitter_if.sv
// Bundle of the sprite blitter's handshake, object-memory and VGA-adapter signals.
// The master side is the blitter; the slave side is the surrounding system.
interface sprite_blitter_if #(
    parameter int AW = 10,
    parameter int XW = 8,
    parameter int YW = 7
);
    logic          start;
    logic [XW-1:0] x0;
    logic [YW-1:0] y0;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic [XW-1:0] vga_x;
    logic [YW-1:0] vga_y;
    logic [7:0]    vga_colour;
    logic          plot;
    logic          busy;
    logic          done;

    modport master (
        input  start, x0, y0, mem_data,
        output mem_addr, vga_x, vga_y, vga_colour, plot, busy, done
    );

    modport slave (
        output start, x0, y0, mem_data,
        input  mem_addr, vga_x, vga_y, vga_colour, plot, busy, done
    );
endinterface

// File: rtl/sprite_blitter.sv
// Sprite blitter: scans a W x H sprite from a 1-cycle-latency ROM and issues one
// VGA pixel write per opaque, on-screen texel at the latched origin.
module sprite_blitter #(
    parameter int         W        = 32,
    parameter int         H        = 32,
    parameter int         AW       = 10,
    parameter int         XW       = 8,
    parameter int         YW       = 7,
    parameter int         SCREEN_W = 160,
    parameter int         SCREEN_H = 120,
    parameter logic [7:0] TRANSP   = 8'hEE
) (
    input  logic              Clock,
    input  logic              Resetn,
    sprite_blitter_if.master  bus
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int RW = (H > 1) ? $clog2(H) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          r_drain;
    logic [XW-1:0] r_x0;
    logic [YW-1:0] r_y0;
    logic          r_done;
    logic          w_last;

    logic          r_vld_p1;
    logic [CW-1:0] r_col_p1;
    logic [RW-1:0] r_row_p1;

    logic          r_plot_p2;
    logic [XW-1:0] r_x_p2;
    logic [YW-1:0] r_y_p2;
    logic [7:0]    r_colour_p2;

    logic [XW:0]   w_sx;
    logic [YW:0]   w_sy;

    // Sums carry one extra bit so off-screen texels clip instead of wrapping.
    function automatic logic on_screen(input logic [XW:0] sx, input logic [YW:0] sy);
        return (sx < (XW+1)'(SCREEN_W)) && (sy < (YW+1)'(SCREEN_H));
    endfunction

    assign w_last = (r_col == CW'(W-1)) && (r_row == RW'(H-1));

    always_ff @(posedge Clock) begin
        if (!Resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_FETCH;
            S_FETCH: if (w_last)    w_next = S_DRAIN;
            S_DRAIN: if (r_drain)   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_col   <= '0;
            r_row   <= '0;
            r_drain <= 1'b0;
            r_x0    <= '0;
            r_y0    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= (r_state == S_DRAIN) && r_drain;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_x0  <= bus.x0;
                        r_y0  <= bus.y0;
                        r_col <= '0;
                        r_row <= '0;
                    end
                end
                S_FETCH: begin
                    r_drain <= 1'b0;
                    if (r_col == CW'(W-1)) begin
                        r_col <= '0;
                        r_row <= r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
                S_DRAIN: r_drain <= ~r_drain;
                default: ;
            endcase
        end
    end

    assign bus.mem_addr = (r_state == S_FETCH) ? AW'({r_row, r_col}) : '0;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = r_done;

    // Stage 1: align texel coordinates with the ROM's registered read data.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_vld_p1 <= 1'b0;
            r_col_p1 <= '0;
            r_row_p1 <= '0;
        end else begin
            r_vld_p1 <= (r_state == S_FETCH);
            r_col_p1 <= r_col;
            r_row_p1 <= r_row;
        end
    end

    assign w_sx = {1'b0, r_x0} + (XW+1)'(r_col_p1);
    assign w_sy = {1'b0, r_y0} + (YW+1)'(r_row_p1);

    // Stage 2: qualify and register the VGA write.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_plot_p2   <= 1'b0;
            r_x_p2      <= '0;
            r_y_p2      <= '0;
            r_colour_p2 <= '0;
        end else begin
            r_plot_p2   <= r_vld_p1 && (bus.mem_data != TRANSP) && on_screen(w_sx, w_sy);
            r_x_p2      <= w_sx[XW-1:0];
            r_y_p2      <= w_sy[YW-1:0];
            r_colour_p2 <= bus.mem_data;
        end
    end

    assign bus.plot       = r_plot_p2;
    assign bus.vga_x      = r_x_p2;
    assign bus.vga_y      = r_y_p2;
    assign bus.vga_colour = r_colour_p2;
endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: full blit, transparency, clipping,
// start handshake and mid-blit reset, checked against a per-cycle texel model.
module tb_sprite_blitter;
    localparam int W = 32, H = 32, AW = 10, XW = 8, YW = 7, N = W * H;

    logic Clock = 1'b0;
    logic Resetn = 1'b0;
    int   rom_mode = 0;
    int   n_checks = 0, n_errors = 0;

    int plots, first_plot, done_cyc, bad, maxx, maxy, non3c, evenx;
    int f_x, f_y, f_c, t_x, t_y, t_c;

    sprite_blitter_if #(.AW(AW), .XW(XW), .YW(YW)) bus ();

    sprite_blitter #(.W(W), .H(H), .AW(AW), .XW(XW), .YW(YW)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus.master)
    );

    always #5 Clock = ~Clock;

    function automatic logic [7:0] rom(input int mode, input int a);
        logic [31:0] av;
        av = a;
        if (mode == 0) return (av[7:0] == 8'hEE) ? 8'h01 : av[7:0];
        return av[0] ? 8'h3C : 8'hEE;
    endfunction

    always_ff @(posedge Clock) bus.mem_data <= rom(rom_mode, int'(bus.mem_addr));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One blit; cycle k is the k-th cycle after the edge that accepts start.
    task automatic blit(input int ox, input int oy, input bit pre, input int ign,
                        input int abort_at, input bit b2b, input int bx, input int by);
        int n, ex, ey, last, eaddr;
        bit ab, ep;
        logic [7:0] ec;
        if (!pre) begin
            @(negedge Clock);
            bus.start = 1'b1; bus.x0 = XW'(ox); bus.y0 = YW'(oy);
        end
        @(posedge Clock);
        #1 bus.start = 1'b0;
        plots = 0; first_plot = -1; done_cyc = -1; bad = 0; maxx = 0; maxy = 0;
        non3c = 0; evenx = 0; f_x = -1; f_y = -1; f_c = -1; t_x = -1; t_y = -1; t_c = -1;
        last = (abort_at > 0) ? N + 6 : N + 3;
        for (int k = 1; k <= last; k++) begin
            @(negedge Clock);
            ab = (abort_at > 0) && (k > abort_at);
            n  = k - 3;
            ep = 1'b0; ec = 8'h00; ex = 0; ey = 0;
            if (!ab && n >= 0 && n < N) begin
                ec = rom(rom_mode, n);
                ex = ox + n % W;
                ey = oy + n / W;
                ep = (ec != 8'hEE) && (ex < 160) && (ey < 120);
            end
            if (bus.plot !== ep) bad++;
            else if (ep && (int'(bus.vga_x) != ex || int'(bus.vga_y) != ey || bus.vga_colour !== ec)) bad++;
            if (bus.busy !== (!ab && k <= N + 2)) bad++;
            if (bus.done !== (!ab && k == N + 3)) bad++;
            eaddr = (!ab && k <= N) ? k - 1 : 0;
            if (int'(bus.mem_addr) != eaddr) bad++;
            if (bus.plot === 1'b1) begin
                plots++;
                if (first_plot < 0) begin
                    first_plot = k; f_x = int'(bus.vga_x); f_y = int'(bus.vga_y); f_c = int'(bus.vga_colour);
                end
                if (int'(bus.vga_x) > maxx) maxx = int'(bus.vga_x);
                if (int'(bus.vga_y) > maxy) maxy = int'(bus.vga_y);
                if (bus.vga_colour !== 8'h3C) non3c++;
                if (bus.vga_x[0] === 1'b0) evenx++;
            end
            if (bus.done === 1'b1) done_cyc = k;
            if (k == 36) begin
                t_x = int'(bus.vga_x); t_y = int'(bus.vga_y); t_c = int'(bus.vga_colour);
            end
            if (ign > 0 && k == ign) begin
                bus.start = 1'b1; bus.x0 = 8'd77; bus.y0 = 7'd3;
            end
            if (ign > 0 && k == ign + 1) bus.start = 1'b0;
            if (abort_at > 0 && k == abort_at) Resetn = 1'b0;
            if (abort_at > 0 && k == abort_at + 1) Resetn = 1'b1;
            if (b2b && k == N + 3) begin
                bus.start = 1'b1; bus.x0 = XW'(bx); bus.y0 = YW'(by);
            end
        end
    endtask

    initial begin
        bus.start = 1'b1; bus.x0 = '0; bus.y0 = '0;
        Resetn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clock);
            check("rst_plot", bus.plot, 0);
            check("rst_busy", bus.busy, 0);
            check("rst_done", bus.done, 0);
            check("rst_addr", bus.mem_addr, 0);
        end
        Resetn = 1'b1; bus.start = 1'b0;
        repeat (2) @(negedge Clock);
        check("rst_nostart_busy", bus.busy, 0);

        rom_mode = 0;
        blit(10, 5, 1'b0, 500, 0, 1'b1, 20, 30);
        check("full_model", bad, 0);
        check("full_plots", plots, 1024);
        check("full_first_cyc", first_plot, 3);
        check("full_first_x", f_x, 10);
        check("full_first_y", f_y, 5);
        check("full_first_c", f_c, 0);
        check("full_t33_x", t_x, 11);
        check("full_t33_y", t_y, 6);
        check("full_t33_c", t_c, 8'h21);
        check("full_done_cyc", done_cyc, 1027);

        blit(20, 30, 1'b1, 0, 0, 1'b0, 0, 0);
        check("b2b_model", bad, 0);
        check("b2b_plots", plots, 1024);
        check("b2b_done_cyc", done_cyc, 1027);

        rom_mode = 1;
        blit(0, 0, 1'b0, 0, 0, 1'b0, 0, 0);
        check("transp_model", bad, 0);
        check("transp_plots", plots, 512);
        check("transp_colour", non3c, 0);
        check("transp_evenx", evenx, 0);
        check("transp_done_cyc", done_cyc, 1027);

        rom_mode = 0;
        blit(150, 100, 1'b0, 0, 0, 1'b0, 0, 0);
        check("clip_model", bad, 0);
        check("clip_plots", plots, 200);
        check("clip_maxx", maxx, 159);
        check("clip_maxy", maxy, 119);
        check("clip_done_cyc", done_cyc, 1027);

        blit(10, 5, 1'b0, 0, 300, 1'b0, 0, 0);
        check("abort_model", bad, 0);
        check("abort_plots", plots, 298);
        check("abort_no_done", done_cyc, -1);

        blit(10, 5, 1'b0, 0, 0, 1'b0, 0, 0);
        check("fresh_model", bad, 0);
        check("fresh_plots", plots, 1024);
        check("fresh_first_cyc", first_plot, 3);
        check("fresh_done_cyc", done_cyc, 1027);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
